// File: rtl/csa_product_accumulator.sv
// rtl/csa_product_accumulator.sv - sums N_TERMS products per frame behind valid/ready handshakes.
// Optional CSA_ACC_SATURATE_EN clamps the sum at all-ones on carry-out instead of wrapping.
module csa_product_accumulator #(
   parameter int WIDTH     = 4,
   parameter int ACC_WIDTH = 16,
   parameter int N_TERMS   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [2*WIDTH-1:0]           product,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         clear,
   output logic [ACC_WIDTH-1:0]         acc_out,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         overflow,
   output logic [$clog2(N_TERMS+1)-1:0] term_count
);

   localparam int CW = $clog2(N_TERMS+1);

   typedef enum logic {S_ACCUM = 1'b0, S_DONE = 1'b1} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_overflow;
   logic [CW-1:0]        r_count;
   logic [ACC_WIDTH:0]   w_sum;
   logic                 w_accept;
   logic                 w_last;

   // One extra bit on the adder captures the carry-out that drives overflow.
   assign w_sum    = {1'b0, r_acc} + {{(ACC_WIDTH+1-2*WIDTH){1'b0}}, product};
   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_count == CW'(N_TERMS-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_ACCUM;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_ACCUM: if (w_accept && w_last) w_next = S_DONE;
         S_DONE:  if (out_ready)          w_next = S_ACCUM;
         default: w_next = S_ACCUM;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_ACCUM: in_ready  = !clear;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc      <= '0;
         r_overflow <= 1'b0;
         r_count    <= '0;
      end else if (r_state == S_ACCUM) begin
         if (clear) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            r_count    <= '0;
         end else if (w_accept) begin
`ifdef CSA_ACC_SATURATE_EN
            // Once clamped the sum stays at all-ones until the frame is drained.
            r_acc <= (w_sum[ACC_WIDTH] || r_overflow) ? '1 : w_sum[ACC_WIDTH-1:0];
`else
            r_acc <= w_sum[ACC_WIDTH-1:0];
`endif
            r_overflow <= r_overflow | w_sum[ACC_WIDTH];
            r_count    <= r_count + CW'(1);
         end
      end else if (out_ready) begin
         r_acc      <= '0;
         r_overflow <= 1'b0;
         r_count    <= '0;
      end
   end

   assign acc_out    = r_acc;
   assign overflow   = r_overflow;
   assign term_count = r_count;

endmodule

// File: tb/tb_csa_product_accumulator.sv
// tb/tb_csa_product_accumulator.sv - scoreboard bench for two accumulator configurations.
// Instance 0 uses defaults; instance 1 uses ACC_WIDTH=8, N_TERMS=2 to reach overflow.
module tb_csa_product_accumulator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] product = '0;
   logic       in_valid = 1'b0;
   logic       clear = 1'b0;
   logic       out_ready = 1'b0;

   logic        in_ready0, out_valid0, overflow0;
   logic [15:0] acc_out0;
   logic [2:0]  term_count0;
   logic        in_ready1, out_valid1, overflow1;
   logic [7:0]  acc_out1;
   logic [1:0]  term_count1;

   csa_product_accumulator #(.WIDTH(4), .ACC_WIDTH(16), .N_TERMS(4)) u_dut0 (
      .clk(clk), .rst(rst), .product(product), .in_valid(in_valid), .in_ready(in_ready0),
      .clear(clear), .acc_out(acc_out0), .out_valid(out_valid0), .out_ready(out_ready),
      .overflow(overflow0), .term_count(term_count0)
   );

   csa_product_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .N_TERMS(2)) u_dut1 (
      .clk(clk), .rst(rst), .product(product), .in_valid(in_valid), .in_ready(in_ready1),
      .clear(clear), .acc_out(acc_out1), .out_valid(out_valid1), .out_ready(out_ready),
      .overflow(overflow1), .term_count(term_count1)
   );

   always #5 clk = ~clk;

   typedef struct {
      int acc;
      int ovf;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;

   // Model: raw arithmetic sum of the products taken in the open frame.
   int NT[2]     = '{4, 2};
   int LIM[2]    = '{65536, 256};
   int m_sum[2]  = '{0, 0};
   int m_cnt[2]  = '{0, 0};
   bit m_done[2] = '{1'b0, 1'b0};

   function automatic int exp_acc(input int k, input int s);
`ifdef CSA_ACC_SATURATE_EN
      return (s >= LIM[k]) ? LIM[k] - 1 : s;
`else
      return s % LIM[k];
`endif
   endfunction

   task automatic check(input string nm, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, k, act, exp, $time);
      end
   endtask

   function automatic int dut_val(input int k, input int which);
      case (which)
         0: return (k == 0) ? int'(in_ready0)   : int'(in_ready1);
         1: return (k == 0) ? int'(out_valid0)  : int'(out_valid1);
         2: return (k == 0) ? int'(acc_out0)    : int'(acc_out1);
         3: return (k == 0) ? int'(overflow0)   : int'(overflow1);
         default: return (k == 0) ? int'(term_count0) : int'(term_count1);
      endcase
   endfunction

   task automatic cyc(input bit v, input int p, input bit c, input bit ordy, input bit r);
      @(negedge clk);
      in_valid  = v;
      product   = p[7:0];
      clear     = c;
      out_ready = ordy;
      rst       = r;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (!r) begin
            check("in_ready",   k, dut_val(k, 0), (!m_done[k] && !c) ? 1 : 0);
            check("out_valid",  k, dut_val(k, 1), m_done[k] ? 1 : 0);
            check("term_count", k, dut_val(k, 4), m_done[k] ? NT[k] : m_cnt[k]);
            check("acc_out",    k, dut_val(k, 2), exp_acc(k, m_sum[k]));
            check("overflow",   k, dut_val(k, 3), (m_sum[k] >= LIM[k]) ? 1 : 0);
         end
         if (r) begin
            if (m_done[k]) begin
               if (k == 0) void'(q0.pop_back()); else void'(q1.pop_back());
            end
            m_done[k] = 1'b0; m_sum[k] = 0; m_cnt[k] = 0;
         end else if (m_done[k]) begin
            if (ordy) begin
               m_done[k] = 1'b0; m_sum[k] = 0; m_cnt[k] = 0;
            end
         end else if (c) begin
            m_sum[k] = 0; m_cnt[k] = 0;
         end else if (v) begin
            m_sum[k] += p[7:0];
            m_cnt[k]++;
            if (m_cnt[k] == NT[k]) begin
               exp_t e;
               e.acc = exp_acc(k, m_sum[k]);
               e.ovf = (m_sum[k] >= LIM[k]) ? 1 : 0;
               if (k == 0) q0.push_back(e); else q1.push_back(e);
               m_done[k] = 1'b1;
            end
         end
      end
   endtask

   // Monitor: pops an expected frame whenever a DUT completes an output handshake.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         for (int k = 0; k < 2; k++) begin
            if (!rst && dut_val(k, 1) == 1 && out_ready) begin
               exp_t e;
               if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                  check("unexpected_frame", k, 1, 0);
               end else begin
                  e = (k == 0) ? q0.pop_front() : q1.pop_front();
                  check("frame_acc", k, dut_val(k, 2), e.acc);
                  check("frame_ovf", k, dut_val(k, 3), e.ovf);
                  check("frame_cnt", k, dut_val(k, 4), NT[k]);
               end
            end
         end
      end
   end

   initial begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      // Defaults: 4 x 12
      for (int i = 0; i < 4; i++) cyc(1, 12, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      // Backpressure: 1..4 then held with in_valid high
      for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 99, 0, 0, 0);
      cyc(1, 99, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 1, 0);
      // Overflow on the 8-bit instance
      cyc(1, 225, 0, 0, 0);
      cyc(1, 225, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 1, 0);
      // Clear wins over a concurrent product
      cyc(1, 5, 0, 1, 0);
      cyc(1, 7, 0, 1, 0);
      cyc(1, 9, 1, 1, 0);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      // Reset mid-frame
      cyc(1, 10, 0, 0, 0);
      cyc(1, 10, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 3, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      // Gaps
      for (int i = 0; i < 8; i++) cyc(i % 2 == 0, 15, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
             $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 79) == 0);
      end
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      check("leftover_frames", 0, q0.size(), 0);
      check("leftover_frames", 1, q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csa_product_accumulator.md
Name: csa_product_accumulator

Overview:
Sequential stage directly downstream of the combinational CSA multiplier (multiplier_csa). Captures successive 2*WIDTH-bit products through a valid/ready handshake and sums a fixed-length frame of N_TERMS products (dot-product / MAC frame). Presents the frame sum with an output valid/ready handshake and a sticky overflow flag.

Parameters:
WIDTH, 4, operand width of upstream multiplier; product input is 2*WIDTH bits
ACC_WIDTH, 16, accumulator/result width; must be >= 2*WIDTH
N_TERMS, 4, products summed per frame; must be >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
product  input  2*WIDTH  unsigned product from multiplier_csa result
in_valid  input  1  product is valid this cycle
in_ready  output  1  block accepts product this cycle
clear  input  1  synchronous frame abort; discards partial sum
acc_out  output  ACC_WIDTH  frame sum, valid when out_valid=1
out_valid  output  1  frame sum available
out_ready  input  1  consumer accepts acc_out
overflow  output  1  sticky: frame sum exceeded ACC_WIDTH bits; valid with out_valid
term_count  output  $clog2(N_TERMS+1)  products accepted in current frame

Behaviour:
- Reset (rst=1 at clk edge, any state): state=ACCUM, acc_out=0, term_count=0, overflow=0, out_valid=0. in_ready becomes 1 on the first cycle after rst deasserts.
- States: ACCUM, DONE.
- ACCUM: in_ready = !clear; out_valid=0. Accept = in_valid && in_ready. On accept: acc <= acc + zero-extended product (ACC_WIDTH-bit, modulo 2^ACC_WIDTH); overflow <= overflow | carry-out; term_count++. When the accept brings term_count to N_TERMS: go to DONE on the same edge.
- DONE: in_ready=0; out_valid=1; acc_out, overflow, term_count=N_TERMS held stable while out_ready=0. On out_valid && out_ready: acc<=0, overflow<=0, term_count<=0, go to ACCUM; in_ready=1 the next cycle (no same-cycle pass-through).
- Latency: the frame sum is visible the cycle after the N_TERMS-th accept edge. Throughput: N_TERMS+1 cycles/frame minimum (one DONE cycle with out_ready=1).
- clear in ACCUM: acc, term_count, overflow <= 0; in_ready=0 that cycle, so a concurrent in_valid product is not accepted (clear wins). clear in DONE: ignored; the frame must be drained via out_ready.
- in_valid while in_ready=0: product ignored; upstream must hold it.
- product is sampled only on accept; changes at other times have no effect.
- N_TERMS=1: every accept goes ACCUM->DONE directly.
- rst overrides clear, handshakes, and state on the same edge.
- Outputs are registered except in_ready, which is combinational from state and clear.

Optional Feature:
Macro CSA_ACC_SATURATE_EN. Defined: on carry-out, acc clamps to 2^ACC_WIDTH-1 and stays clamped for the rest of the frame; overflow is still set. Not defined: sum wraps modulo 2^ACC_WIDTH and overflow is set. Handshake and timing are identical in both builds.

Test Plan:
- Defaults. Reset, then four accepts of product=12 (2*6) on consecutive cycles -> out_valid=1 the next cycle, acc_out=48, overflow=0, term_count=4; out_ready=1 -> ACCUM, acc_out=0.
- Backpressure. Complete a frame of 1,2,3,4 with out_ready=0 for 5 cycles and in_valid=1 throughout -> acc_out=10 stable, in_ready=0, no extra term accepted; out_ready=1 -> next frame starts from 0.
- Overflow, ACC_WIDTH=8. Products 225 and 225 with N_TERMS=2 -> acc_out=194, overflow=1. With CSA_ACC_SATURATE_EN defined -> acc_out=255, overflow=1.
- Clear. Accept 5, then 7, then assert clear with in_valid=1 and product=9 -> in_ready=0 and 9 is not taken; then accept 1,1,1,1 -> acc_out=4.
- Reset mid-frame. After two accepts (sum 20), assert rst for 1 cycle -> all outputs 0; then four products of 3 -> acc_out=12.
- Gaps. in_valid toggles 1,0,1,0,... with products 15,15,15,15 -> out_valid only after the 4th accept, acc_out=60, term_count increments only on accepts.
